// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between a show-ahead FIFO read port, the stream reader and
// the downstream stream consumer.
interface fifo_stream_reader_if #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
);
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_empty;
   logic             fifo_req;
   logic [WIDTH-1:0] o_dat;
   logic             o_val;
   logic             o_sop;
   logic             o_eop;
   logic             o_rdy;
   logic [CNTW-1:0]  o_pkt_cnt;

   modport master (
      input  fifo_data, fifo_empty, o_rdy,
      output fifo_req, o_dat, o_val, o_sop, o_eop, o_pkt_cnt
   );

   modport slave (
      output fifo_data, fifo_empty, o_rdy,
      input  fifo_req, o_dat, o_val, o_sop, o_eop, o_pkt_cnt
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Show-ahead FIFO read port to registered valid/ready stream with sop/eop
// framing every PKTLEN words and a completed-packet counter.
module fifo_stream_reader #(
   parameter int WIDTH  = 8,
   parameter int PKTLEN = 4,
   parameter int CNTW   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_stream_reader_if.master bus
);
   localparam int IDXW = (PKTLEN > 1) ? $clog2(PKTLEN) : 1;
   localparam int ENTW = WIDTH + 2;

   // Buffer entries are {data, sop, eop}; head_p0 drives the stream, skid_p1 absorbs backpressure.
   logic [ENTW-1:0] head_p0;
   logic [ENTW-1:0] skid_p1;
   logic [ENTW-1:0] in_ent;
   logic [1:0]      fill;
   logic [IDXW-1:0] idx;
   logic [CNTW-1:0] pkt_cnt;
   logic            push;
   logic            pop;
   logic            in_sop;
   logic            in_eop;

   // Request depends only on registered fill and the FIFO's registered empty flag.
   assign push     = ~reset & ~bus.fifo_empty & (fill != 2'd2);
   assign pop      = (fill != 2'd0) & bus.o_rdy;
   assign in_sop   = (idx == '0);
   assign in_eop   = (idx == IDXW'(PKTLEN - 1));
   assign in_ent   = {bus.fifo_data, in_sop, in_eop};

   assign bus.fifo_req  = push;
   assign bus.o_val     = (fill != 2'd0);
   assign bus.o_dat     = head_p0[ENTW-1:2];
   assign bus.o_sop     = head_p0[1];
   assign bus.o_eop     = head_p0[0];
   assign bus.o_pkt_cnt = pkt_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         head_p0 <= '0;
         skid_p1 <= '0;
         fill    <= 2'd0;
         idx     <= '0;
         pkt_cnt <= '0;
      end else begin
         if (push) begin
            idx <= in_eop ? '0 : idx + 1'b1;
         end

         case ({push, pop})
            2'b10: begin
               fill <= fill + 2'd1;
               if (fill == 2'd0) begin
                  head_p0 <= in_ent;
               end else begin
                  skid_p1 <= in_ent;
               end
            end
            2'b01: begin
               fill <= fill - 2'd1;
               if (fill == 2'd2) begin
                  head_p0 <= skid_p1;
               end
            end
            // Push and pop together only happen at fill == 1: new word replaces head.
            2'b11: begin
               head_p0 <= in_ent;
            end
            default: begin
            end
         endcase

         if (pop && head_p0[0]) begin
            pkt_cnt <= pkt_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader: queue-based FIFO and stream model,
// one instance with PKTLEN=4 and one with PKTLEN=1, CNTW=2.
module tb_fifo_stream_reader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   fifo_stream_reader_if #(.WIDTH(8), .CNTW(16)) ia ();
   fifo_stream_reader_if #(.WIDTH(8), .CNTW(2))  ib ();

   fifo_stream_reader #(.WIDTH(8), .PKTLEN(4), .CNTW(16)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (ia)
   );

   fifo_stream_reader #(.WIDTH(8), .PKTLEN(1), .CNTW(2)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (ib)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] fq[$];      // words still held in the modelled FIFO
   logic [9:0] expq[$];    // {dat, sop, eop} accepted by the reader, not yet delivered
   int         push_total; // words accepted since last reset
   int         pkt_a;      // packets completed since last reset
   int         cyc;
   bit         did_push;
   bit         did_pop;
   bit         pop_sop;
   int         pop_cnt;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of instance A, called at a negedge; returns at the next negedge.
   task automatic cycle_a(input bit rdy, input bit starve);
      logic [7:0] w;
      ia.o_rdy      = rdy;
      ia.fifo_empty = starve || (fq.size() == 0);
      ia.fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
      #1;
      check_eq("req_while_empty", 32'(ia.fifo_req & ia.fifo_empty), 32'(0));
      check_eq("req", 32'(ia.fifo_req),
               32'(!rst_a && !ia.fifo_empty && (expq.size() < 2)));
      check_eq("val", 32'(ia.o_val), 32'(expq.size() != 0));
      check_eq("fill_le_2", 32'(expq.size() <= 2), 32'(1));
      check_eq("pkt_cnt", 32'(ia.o_pkt_cnt), 32'(pkt_a[15:0]));
      if (ia.o_val && (expq.size() != 0))
         check_eq("head", 32'({ia.o_dat, ia.o_sop, ia.o_eop}), 32'(expq[0]));
      did_push = ia.fifo_req;
      did_pop  = ia.o_val & rdy;
      pop_sop  = ia.o_sop;
      pop_cnt  = 32'(ia.o_pkt_cnt);
      @(posedge clk);
      cyc++;
      if (rst_a) begin
         expq.delete();
         push_total = 0;
         pkt_a      = 0;
         did_push   = 1'b0;
         did_pop    = 1'b0;
      end else begin
         if (did_pop && (expq.size() != 0)) begin
            if (expq[0][0]) pkt_a++;
            void'(expq.pop_front());
         end
         if (did_push && (fq.size() != 0)) begin
            w = fq.pop_front();
            expq.push_back({w, (push_total % 4) == 0, (push_total % 4) == 3});
            push_total++;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int np, nv, fp, lp, fv, lv, nb, k;
      logic [7:0] fqb[$];
      logic [7:0] ebq[$];
      bit pb;

      rst_a = 1'b1;
      rst_b = 1'b1;
      ia.o_rdy = 1'b1; ia.fifo_empty = 1'b0; ia.fifo_data = 8'hAA;
      ib.o_rdy = 1'b0; ib.fifo_empty = 1'b1; ib.fifo_data = 8'h00;
      push_total = 0; pkt_a = 0; cyc = 0;
      fq = '{8'hAA, 8'hBB, 8'hCC};
      @(posedge clk);
      @(negedge clk);

      // Reset held with a non-empty FIFO and ready downstream
      for (int i = 0; i < 3; i++) begin
         cycle_a(1'b1, 1'b0);
         check_eq("rst_req", 32'(ia.fifo_req), 32'(0));
         check_eq("rst_val", 32'(ia.o_val), 32'(0));
         check_eq("rst_dat", 32'(ia.o_dat), 32'(0));
         check_eq("rst_cnt", 32'(ia.o_pkt_cnt), 32'(0));
      end
      fq.delete();
      rst_a = 1'b0;

      // Streaming 0..7
      for (int i = 0; i < 8; i++) fq.push_back(8'(i));
      np = 0; nv = 0; fp = -1; lp = -1; fv = -1; lv = -1;
      for (int i = 0; i < 30 && nv < 8; i++) begin
         cycle_a(1'b1, 1'b0);
         if (did_push) begin if (fp < 0) fp = cyc; lp = cyc; np++; end
         if (did_pop)  begin if (fv < 0) fv = cyc; lv = cyc; nv++; end
      end
      check_eq("stream_reads", 32'(np), 32'(8));
      check_eq("stream_req_run", 32'(lp - fp + 1), 32'(8));
      check_eq("stream_pops", 32'(nv), 32'(8));
      check_eq("stream_val_run", 32'(lv - fv + 1), 32'(8));
      check_eq("stream_latency", 32'(fv - fp), 32'(1));
      check_eq("stream_pkt_cnt", 32'(ia.o_pkt_cnt), 32'(2));

      // Backpressure 0..5
      for (int i = 0; i < 6; i++) fq.push_back(8'(i));
      np = 0;
      for (int i = 0; i < 6; i++) begin
         cycle_a(1'b0, 1'b0);
         if (did_push) np++;
      end
      check_eq("bp_reads", 32'(np), 32'(2));
      check_eq("bp_hold_dat", 32'(ia.o_dat), 32'(0));
      check_eq("bp_hold_val", 32'(ia.o_val), 32'(1));
      nv = 0;
      for (int i = 0; i < 40 && nv < 6; i++) begin
         cycle_a(i[0] == 1'b0, 1'b0);
         if (did_pop) nv++;
      end
      check_eq("bp_delivered", 32'(nv), 32'(6));
      check_eq("bp_fifo_drained", 32'(fq.size()), 32'(0));

      // Starvation with random empty, then random ready as well
      for (int i = 0; i < 40; i++) fq.push_back(8'($urandom));
      for (int i = 0; i < 400 && (fq.size() != 0 || expq.size() != 0); i++)
         cycle_a(1'b1, $urandom_range(0, 1) == 1);
      check_eq("starve_drained", 32'(fq.size() + expq.size()), 32'(0));
      for (int i = 0; i < 30; i++) fq.push_back(8'($urandom));
      for (int i = 0; i < 500 && (fq.size() != 0 || expq.size() != 0); i++)
         cycle_a($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      check_eq("random_drained", 32'(fq.size() + expq.size()), 32'(0));

      // Mid-packet reset after two delivered words of a fresh packet
      rst_a = 1'b1;
      cycle_a(1'b1, 1'b0);
      rst_a = 1'b0;
      for (int i = 0; i < 4; i++) fq.push_back(8'h40 + 8'(i));
      nv = 0;
      for (int i = 0; i < 20 && nv < 2; i++) begin
         cycle_a(1'b1, 1'b0);
         if (did_pop) nv++;
      end
      check_eq("mpr_pre_pops", 32'(nv), 32'(2));
      rst_a = 1'b1;
      cycle_a(1'b1, 1'b0);
      rst_a = 1'b0;
      for (int i = 0; i < 4; i++) fq.push_back(8'h50 + 8'(i));
      k = 0;
      for (int i = 0; i < 20 && k == 0; i++) begin
         cycle_a(1'b1, 1'b0);
         if (did_pop) begin
            k = 1;
            check_eq("mpr_sop", 32'(pop_sop), 32'(1));
            check_eq("mpr_cnt", 32'(pop_cnt), 32'(0));
         end
      end
      check_eq("mpr_delivered", 32'(k), 32'(1));
      for (int i = 0; i < 40 && (fq.size() != 0 || expq.size() != 0); i++)
         cycle_a(1'b1, 1'b0);

      // Instance B: one-word packets and a 2-bit wrapping counter
      rst_b = 1'b0;
      for (int i = 0; i < 5; i++) fqb.push_back(8'h60 + 8'(i));
      ib.o_rdy = 1'b1;
      nb = 0;
      for (int i = 0; i < 30 && nb < 5; i++) begin
         ib.fifo_empty = (fqb.size() == 0);
         ib.fifo_data  = (fqb.size() != 0) ? fqb[0] : 8'h00;
         #1;
         check_eq("b_req_while_empty", 32'(ib.fifo_req & ib.fifo_empty), 32'(0));
         pb = ib.o_val;
         if (pb) begin
            check_eq("b_dat", 32'(ib.o_dat), 32'((ebq.size() != 0) ? ebq[0] : 8'hxx));
            check_eq("b_sop", 32'(ib.o_sop), 32'(1));
            check_eq("b_eop", 32'(ib.o_eop), 32'(1));
         end
         k = ib.fifo_req ? 1 : 0;
         @(posedge clk);
         if (pb && ebq.size() != 0) void'(ebq.pop_front());
         if (k == 1 && fqb.size() != 0) ebq.push_back(fqb.pop_front());
         @(negedge clk);
         if (pb) begin
            nb++;
            check_eq("b_pkt_cnt", 32'(ib.o_pkt_cnt), 32'(nb % 4));
         end
      end
      check_eq("b_delivered", 32'(nb), 32'(5));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
